// File: rtl/decoder_stream.sv
// Select-field decoder (one-hot / thermometer / inverted / hold) feeding
// a small in-order output FIFO, with sticky range error and accept counter.
module decoder_stream #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_data,
    output logic               err,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   dec_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(NUM_OUT);

    logic [NUM_OUT-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [NUM_OUT-1:0] last_pat;
    logic [NUM_OUT-1:0] onehot;
    logic [NUM_OUT-1:0] thermo;
    logic [NUM_OUT-1:0] dec_pat;
    logic               in_range;
    logic               dec_err;
    logic               push;
    logic               pop;

    assign in_ready  = (occ != FULL_OCC);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_range  = {1'b0, in_sel} < SEL_LIM;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        onehot = '0;
        thermo = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = ({1'b0, in_sel} == (SEL_W + 1)'(i));
            thermo[i] = ({1'b0, in_sel} >= (SEL_W + 1)'(i));
        end
    end

    // Out-of-range selects write all-zero; hold mode skips the range check.
    always_comb begin
        dec_pat = '0;
        dec_err = 1'b0;
        unique case (in_mode)
            2'b00: begin
                dec_pat = in_range ? onehot : '0;
                dec_err = !in_range;
            end
            2'b01: begin
                dec_pat = in_range ? thermo : '0;
                dec_err = !in_range;
            end
            2'b10: begin
                dec_pat = in_range ? ~onehot : '0;
                dec_err = !in_range;
            end
            2'b11: begin
                dec_pat = last_pat;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= dec_pat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            last_pat  <= '0;
            err       <= 1'b0;
            dec_count <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_pat  <= dec_pat;
                dec_count <= dec_count + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            // A new error wins over a simultaneous clear.
            if (push && dec_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream: a default instance and a NUM_OUT=6 / CNT_W=4
// instance driven by the same stimulus, checked against hand-computed values.
module tb_decoder_stream;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] in_sel = '0;
    logic [1:0] in_mode = '0;

    logic       in_ready_a, out_valid_a, err_a;
    logic [7:0] out_data_a, dec_count_a;
    logic       in_ready_b, out_valid_b, err_b;
    logic [5:0] out_data_b;
    logic [3:0] dec_count_b;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    decoder_stream dut_a (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_sel    (in_sel),
        .in_mode   (in_mode),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .err       (err_a),
        .err_clr   (err_clr),
        .dec_count (dec_count_a)
    );

    decoder_stream #(
        .SEL_W   (3),
        .NUM_OUT (6),
        .DEPTH   (2),
        .CNT_W   (4)
    ) dut_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_sel    (in_sel),
        .in_mode   (in_mode),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .err       (err_b),
        .err_clr   (err_clr),
        .dec_count (dec_count_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] pat_a;
        logic [5:0] pat_b;
        logic       err_b;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid_a"}, 32'(out_valid_a), 32'd0);
        check({tag, " data_a"}, 32'(out_data_a), 32'd0);
        check({tag, " valid_b"}, 32'(out_valid_b), 32'd0);
        check({tag, " ready_a"}, 32'(in_ready_a), 32'd1);
    endtask

    task automatic check_cnt(input string tag);
        check({tag, " cnt_a"}, 32'(dec_count_a), 32'(exp_cnt % 256));
        check({tag, " cnt_b"}, 32'(dec_count_b), 32'(exp_cnt % 16));
    endtask

    initial begin
        vecs[0]  = '{3'd5, 2'b00, 8'b0010_0000, 6'b10_0000, 1'b0};
        vecs[1]  = '{3'd2, 2'b01, 8'b0000_0111, 6'b00_0111, 1'b0};
        vecs[2]  = '{3'd0, 2'b10, 8'b1111_1110, 6'b11_1110, 1'b0};
        vecs[3]  = '{3'd3, 2'b11, 8'b1111_1110, 6'b11_1110, 1'b0};
        vecs[4]  = '{3'd7, 2'b00, 8'b1000_0000, 6'b00_0000, 1'b1};
        vecs[5]  = '{3'd0, 2'b11, 8'b1000_0000, 6'b00_0000, 1'b0};
        vecs[6]  = '{3'd7, 2'b01, 8'b1111_1111, 6'b00_0000, 1'b1};
        vecs[7]  = '{3'd6, 2'b10, 8'b1011_1111, 6'b00_0000, 1'b1};
        vecs[8]  = '{3'd5, 2'b10, 8'b1101_1111, 6'b01_1111, 1'b0};
        vecs[9]  = '{3'd5, 2'b01, 8'b0011_1111, 6'b11_1111, 1'b0};
        vecs[10] = '{3'd0, 2'b00, 8'b0000_0001, 6'b00_0001, 1'b0};
        vecs[11] = '{3'd7, 2'b11, 8'b0000_0001, 6'b00_0001, 1'b0};

        #1;
        check_idle("rst");
        check("rst err_a", 32'(err_a), 32'd0);
        check("rst err_b", 32'(err_b), 32'd0);
        check_cnt("rst");
        tick();
        tick();
        reset = 1'b0;

        // One accept per vector into an empty FIFO, popped the next cycle.
        for (int i = 0; i < 12; i++) begin
            in_valid  = 1'b1;
            in_sel    = vecs[i].sel;
            in_mode   = vecs[i].mode;
            out_ready = 1'b1;
            tick();
            exp_cnt++;
            in_valid = 1'b0;
            check($sformatf("v%0d valid_a", i), 32'(out_valid_a), 32'd1);
            check($sformatf("v%0d data_a", i), 32'(out_data_a), 32'(vecs[i].pat_a));
            check($sformatf("v%0d data_b", i), 32'(out_data_b), 32'(vecs[i].pat_b));
            check($sformatf("v%0d err_b", i), 32'(err_b), 32'(vecs[i].err_b));
            check($sformatf("v%0d err_a", i), 32'(err_a), 32'd0);
            check_cnt($sformatf("v%0d", i));
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check_idle($sformatf("v%0d pop", i));
            check($sformatf("v%0d clr err_b", i), 32'(err_b), 32'd0);
        end

        // Sticky error: clear alone, then clear colliding with a new error.
        in_valid = 1'b1;
        in_sel   = 3'd7;
        in_mode  = 2'b00;
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        check("e1 err_b", 32'(err_b), 32'd1);
        check("e1 data_b", 32'(out_data_b), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("e1 clr err_b", 32'(err_b), 32'd0);
        in_valid = 1'b1;
        err_clr  = 1'b1;
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        check("e2 err_b", 32'(err_b), 32'd1);
        tick();
        check("e2 sticky err_b", 32'(err_b), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("e2 clr err_b", 32'(err_b), 32'd0);

        // Backpressure: fill DEPTH=2, third request held, drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_mode   = 2'b00;
        tick();
        exp_cnt++;
        check("bp1 ready_a", 32'(in_ready_a), 32'd1);
        check("bp1 data_a", 32'(out_data_a), 32'h02);
        in_sel = 3'd2;
        tick();
        exp_cnt++;
        check("bp2 ready_a", 32'(in_ready_a), 32'd0);
        check("bp2 ready_b", 32'(in_ready_b), 32'd0);
        in_sel  = 3'd6;
        in_mode = 2'b01;
        tick();
        check("bp3 ready_a", 32'(in_ready_a), 32'd0);
        check("bp3 data_a", 32'(out_data_a), 32'h02);
        check("bp3 err_b", 32'(err_b), 32'd0);
        check_cnt("bp3");
        in_sel  = 3'd3;
        in_mode = 2'b00;
        out_ready = 1'b1;
        tick();
        check("bp4 data_a", 32'(out_data_a), 32'h04);
        check("bp4 ready_a", 32'(in_ready_a), 32'd1);
        check_cnt("bp4");
        tick();
        exp_cnt++;
        check("bp5 valid_a", 32'(out_valid_a), 32'd1);
        check("bp5 data_a", 32'(out_data_a), 32'h08);
        check("bp5 data_b", 32'(out_data_b), 32'h08);
        check_cnt("bp5");
        in_valid = 1'b0;
        tick();
        check_idle("bp6");

        // Asynchronous reset with a full FIFO and a pending error.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd7;
        in_mode   = 2'b00;
        tick();
        in_sel  = 3'd4;
        in_mode = 2'b01;
        tick();
        in_valid = 1'b0;
        check("full ready_a", 32'(in_ready_a), 32'd0);
        check("full err_b", 32'(err_b), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("arst");
        check("arst err_b", 32'(err_b), 32'd0);
        check("arst ready_b", 32'(in_ready_b), 32'd1);
        exp_cnt = 0;
        check_cnt("arst");
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_idle("stale");

        // Hold after reset replays the all-zero last pattern; counter wraps.
        in_valid = 1'b1;
        in_sel   = 3'd3;
        in_mode  = 2'b11;
        tick();
        exp_cnt++;
        check("hold0 valid_a", 32'(out_valid_a), 32'd1);
        check("hold0 data_a", 32'(out_data_a), 32'd0);
        check("hold0 data_b", 32'(out_data_b), 32'd0);
        in_sel  = 3'd0;
        in_mode = 2'b00;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_cnt++;
        end
        in_valid = 1'b0;
        check("wrap cnt_a", 32'(dec_count_a), 32'd17);
        check("wrap cnt_b", 32'(dec_count_b), 32'd1);
        check("wrap data_a", 32'(out_data_a), 32'h01);
        tick();
        check_idle("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
